// File: rtl/tx_segment_reader.sv
// Read-side sequencer for the Ethernet TX pixel path: walks one segment through
// the VRAM B-ports or replays it from the segment cache, filling the cache on txid 1.
module tx_segment_reader #(
  parameter int PIXELS_PER_SEG = 360,
  parameter int RD_LAT         = 2,
  parameter int VRAM_AW        = 24
) (
  input  logic               clk125MHz,
  input  logic               rst,
  input  logic               start,
  input  logic [7:0]         txid,
  input  logic [7:0]         segment_num,
  input  logic               abort,
  output logic [VRAM_AW-1:0] vram_addrb,
  output logic [2:0]         color_sel,
  output logic               cache_wr_en,
  output logic [12:0]        cache_wr_addr,
  output logic [12:0]        cache_rd_addr,
  output logic               src_vram,
  output logic               byte_valid,
  output logic [10:0]        byte_idx,
  output logic               busy,
  output logic               done,
  output logic               cache_valid,
  output logic               cache_miss
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int         BYTES  = 3 * PIXELS_PER_SEG;
  localparam logic [10:0] LAST_K = 11'(BYTES - 1);
  localparam int         DW     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [DW-1:0] LAST_DRAIN = DW'(RD_LAT - 1);

  localparam logic [2:0] COLOR_R = 3'd0;
  localparam logic [2:0] COLOR_G = 3'd2;
  localparam logic [2:0] COLOR_B = 3'd1;

  logic [1:0]         state;
  logic [10:0]        k_cnt;
  logic [1:0]         phase;
  logic [VRAM_AW-1:0] pix_addr;
  logic [DW-1:0]      drain_cnt;
  logic               fill_mode;
  logic               src_vram_q;
  logic               cache_valid_q;
  logic               cache_miss_q;
  logic [2:0]         issue_color;
  logic               start_ok;

  logic               pipe_valid [RD_LAT];
  logic [10:0]        pipe_idx   [RD_LAT];
  logic [2:0]         pipe_color [RD_LAT];
  logic               pipe_wr    [RD_LAT];

  assign start_ok = start && (state == S_IDLE);

  always_comb begin
    issue_color = COLOR_R;
    case (phase)
      2'd1:    issue_color = COLOR_G;
      2'd2:    issue_color = COLOR_B;
      default: issue_color = COLOR_R;
    endcase
  end

  // Abort beats start; an aborted fill leaves the cache marked invalid.
  always_ff @(posedge clk125MHz) begin
    if (rst) begin
      state         <= S_IDLE;
      k_cnt         <= '0;
      phase         <= '0;
      pix_addr      <= '0;
      drain_cnt     <= '0;
      fill_mode     <= 1'b0;
      src_vram_q    <= 1'b0;
      cache_valid_q <= 1'b0;
      cache_miss_q  <= 1'b0;
    end else if (abort) begin
      if (state != S_IDLE && fill_mode) begin
        cache_valid_q <= 1'b0;
      end
      state        <= S_IDLE;
      cache_miss_q <= 1'b0;
    end else begin
      cache_miss_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            state        <= S_ISSUE;
            k_cnt        <= '0;
            phase        <= '0;
            pix_addr     <= VRAM_AW'(segment_num) * VRAM_AW'(PIXELS_PER_SEG);
            drain_cnt    <= '0;
            fill_mode    <= (txid == 8'd1);
            src_vram_q   <= (txid == 8'd1) || !cache_valid_q;
            cache_miss_q <= (txid >= 8'd2) && !cache_valid_q;
            if (txid == 8'd1) begin
              cache_valid_q <= 1'b0;
            end
          end
        end
        S_ISSUE: begin
          if (k_cnt == LAST_K) begin
            state     <= S_DRAIN;
            drain_cnt <= '0;
          end else begin
            k_cnt <= k_cnt + 11'd1;
            if (phase == 2'd2) begin
              phase    <= '0;
              pix_addr <= pix_addr + VRAM_AW'(1);
            end else begin
              phase <= phase + 2'd1;
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt == LAST_DRAIN) begin
            state <= S_DONE;
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          if (fill_mode) begin
            cache_valid_q <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Return pipeline mirrors the memory read latency so tags line up with data.
  always_ff @(posedge clk125MHz) begin
    if (rst || abort) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_valid[i] <= 1'b0;
        pipe_idx[i]   <= '0;
        pipe_color[i] <= '0;
        pipe_wr[i]    <= 1'b0;
      end
    end else begin
      pipe_valid[0] <= (state == S_ISSUE);
      pipe_idx[0]   <= k_cnt;
      pipe_color[0] <= issue_color;
      pipe_wr[0]    <= (state == S_ISSUE) && fill_mode;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_idx[i]   <= pipe_idx[i-1];
        pipe_color[i] <= pipe_color[i-1];
        pipe_wr[i]    <= pipe_wr[i-1];
      end
    end
  end

  assign vram_addrb    = pix_addr;
  assign cache_rd_addr = {2'b00, k_cnt};
  assign byte_valid    = pipe_valid[RD_LAT-1];
  assign byte_idx      = pipe_idx[RD_LAT-1];
  assign color_sel     = pipe_color[RD_LAT-1];
  assign cache_wr_en   = pipe_valid[RD_LAT-1] && pipe_wr[RD_LAT-1];
  assign cache_wr_addr = {2'b00, pipe_idx[RD_LAT-1]};
  assign src_vram      = src_vram_q;
  assign busy          = (state != S_IDLE);
  assign done          = (state == S_DONE);
  assign cache_valid   = cache_valid_q;
  assign cache_miss    = cache_miss_q;

endmodule

// File: tb/tb_tx_segment_reader.sv
// Directed bench for tx_segment_reader: fill, replay, miss, max segment,
// abort, reset and back-to-back segments against hand-derived timing.
module tb_tx_segment_reader;

  localparam int PIXELS  = 360;
  localparam int RD_LAT  = 2;
  localparam int VRAM_AW = 24;
  localparam int BYTES   = 3 * PIXELS;
  localparam int DONE_CYC = 1 + BYTES + RD_LAT;

  logic               clk125MHz;
  logic               rst;
  logic               start;
  logic [7:0]         txid;
  logic [7:0]         segment_num;
  logic               abort;
  logic [VRAM_AW-1:0] vram_addrb;
  logic [2:0]         color_sel;
  logic               cache_wr_en;
  logic [12:0]        cache_wr_addr;
  logic [12:0]        cache_rd_addr;
  logic               src_vram;
  logic               byte_valid;
  logic [10:0]        byte_idx;
  logic               busy;
  logic               done;
  logic               cache_valid;
  logic               cache_miss;

  int checks = 0;
  int errors = 0;

  int st_valid_cnt, st_wr_cnt, st_done_cnt, st_done_cyc;
  int st_mis_addr, st_mis_valid, st_mis_wr, st_mis_busy, st_mis_miss;
  logic [VRAM_AW-1:0] st_first_addr, st_last_addr;
  logic st_src, st_cv_first, st_cv_end;

  tx_segment_reader #(
    .PIXELS_PER_SEG(PIXELS),
    .RD_LAT        (RD_LAT),
    .VRAM_AW       (VRAM_AW)
  ) dut (
    .clk125MHz    (clk125MHz),
    .rst          (rst),
    .start        (start),
    .txid         (txid),
    .segment_num  (segment_num),
    .abort        (abort),
    .vram_addrb   (vram_addrb),
    .color_sel    (color_sel),
    .cache_wr_en  (cache_wr_en),
    .cache_wr_addr(cache_wr_addr),
    .cache_rd_addr(cache_rd_addr),
    .src_vram     (src_vram),
    .byte_valid   (byte_valid),
    .byte_idx     (byte_idx),
    .busy         (busy),
    .done         (done),
    .cache_valid  (cache_valid),
    .cache_miss   (cache_miss)
  );

  initial clk125MHz = 1'b0;
  always #4 clk125MHz = ~clk125MHz;

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [2:0] exp_color(input int i);
    case (i % 3)
      0:       return 3'd0;
      1:       return 3'd2;
      default: return 3'd1;
    endcase
  endfunction

  // Start one segment at the current cycle and gather per-cycle statistics
  // against the expected timing model for end_cyc cycles.
  task automatic stream(input logic [7:0] t_id, input logic [7:0] seg, input int abort_k,
                        input bit extra, input bit exp_miss, input int end_cyc);
    int abort_cyc, k, vi, base;
    bit exp_v, exp_busy;
    st_valid_cnt = 0; st_wr_cnt = 0; st_done_cnt = 0; st_done_cyc = -1;
    st_mis_addr = 0; st_mis_valid = 0; st_mis_wr = 0; st_mis_busy = 0; st_mis_miss = 0;
    base = int'(seg) * PIXELS;
    abort_cyc = (abort_k >= 0) ? abort_k + 1 : 100000;
    txid = t_id; segment_num = seg; start = 1'b1; abort = 1'b0;
    for (int cyc = 1; cyc <= end_cyc; cyc++) begin
      @(negedge clk125MHz);
      k = cyc - 1;
      if (k < BYTES && cyc <= abort_cyc) begin
        if (vram_addrb !== VRAM_AW'(base + k / 3)) st_mis_addr++;
        if (cache_rd_addr !== 13'(k)) st_mis_addr++;
      end
      if (cyc == 1) begin
        st_first_addr = vram_addrb;
        st_src = src_vram;
        st_cv_first = cache_valid;
      end
      if (cyc == BYTES) st_last_addr = vram_addrb;
      vi = cyc - 1 - RD_LAT;
      exp_v = (vi >= 0) && (vi < BYTES) && (cyc <= abort_cyc);
      exp_busy = (cyc <= DONE_CYC) && (cyc <= abort_cyc);
      if (byte_valid === 1'b1) st_valid_cnt++;
      if (byte_valid !== exp_v) st_mis_valid++;
      else if (exp_v && (byte_idx !== 11'(vi) || color_sel !== exp_color(vi))) st_mis_valid++;
      if (cache_wr_en === 1'b1) st_wr_cnt++;
      if (cache_wr_en !== (exp_v && t_id == 8'd1)) st_mis_wr++;
      else if (cache_wr_en === 1'b1 && cache_wr_addr !== 13'(vi)) st_mis_wr++;
      if (busy !== exp_busy) st_mis_busy++;
      if (done === 1'b1) begin
        st_done_cnt++;
        st_done_cyc = cyc;
      end
      if (cache_miss !== (cyc == 1 && exp_miss)) st_mis_miss++;
      start = extra && (cyc == 100 || cyc == DONE_CYC);
      abort = (cyc == abort_cyc);
    end
    st_cv_end = cache_valid;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; abort = 1'b0; txid = 8'd0; segment_num = 8'd0;
    repeat (3) @(negedge clk125MHz);
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy_done: got %b%b expected 00", busy, done); end
    checks++; if (byte_valid !== 1'b0 || cache_wr_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid_wr: got %b%b expected 00", byte_valid, cache_wr_en); end
    checks++; if (vram_addrb !== '0 || cache_rd_addr !== '0 || cache_wr_addr !== '0) begin errors++; $display("[TB] FAIL reset_addr: got %0d/%0d/%0d expected 0/0/0", vram_addrb, cache_rd_addr, cache_wr_addr); end
    checks++; if (byte_idx !== '0 || color_sel !== '0) begin errors++; $display("[TB] FAIL reset_idx_color: got %0d/%0d expected 0/0", byte_idx, color_sel); end
    checks++; if (src_vram !== 1'b0 || cache_valid !== 1'b0 || cache_miss !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags: got %b%b%b expected 000", src_vram, cache_valid, cache_miss); end
  endtask

  task automatic test_fill;
    stream(8'd1, 8'd0, -1, 1'b0, 1'b0, 1090);
    checks++; if (st_first_addr !== 24'd0) begin errors++; $display("[TB] FAIL fill_first_addr: got %0d expected 0", st_first_addr); end
    checks++; if (st_last_addr !== 24'd359) begin errors++; $display("[TB] FAIL fill_last_addr: got %0d expected 359", st_last_addr); end
    checks++; if (st_mis_addr !== 0) begin errors++; $display("[TB] FAIL fill_addr_seq: got %0d bad expected 0", st_mis_addr); end
    checks++; if (st_valid_cnt !== BYTES) begin errors++; $display("[TB] FAIL fill_valid_cnt: got %0d expected %0d", st_valid_cnt, BYTES); end
    checks++; if (st_mis_valid !== 0) begin errors++; $display("[TB] FAIL fill_valid_seq: got %0d bad expected 0", st_mis_valid); end
    checks++; if (st_wr_cnt !== BYTES) begin errors++; $display("[TB] FAIL fill_wr_cnt: got %0d expected %0d", st_wr_cnt, BYTES); end
    checks++; if (st_mis_wr !== 0) begin errors++; $display("[TB] FAIL fill_wr_seq: got %0d bad expected 0", st_mis_wr); end
    checks++; if (st_done_cnt !== 1 || st_done_cyc !== DONE_CYC) begin errors++; $display("[TB] FAIL fill_done: got %0d at %0d expected 1 at %0d", st_done_cnt, st_done_cyc, DONE_CYC); end
    checks++; if (st_mis_busy !== 0) begin errors++; $display("[TB] FAIL fill_busy: got %0d bad expected 0", st_mis_busy); end
    checks++; if (st_src !== 1'b1 || st_cv_first !== 1'b0) begin errors++; $display("[TB] FAIL fill_src_cv: got %b%b expected 10", st_src, st_cv_first); end
    checks++; if (st_cv_end !== 1'b1) begin errors++; $display("[TB] FAIL fill_cache_valid: got %b expected 1", st_cv_end); end
    checks++; if (st_mis_miss !== 0) begin errors++; $display("[TB] FAIL fill_miss: got %0d bad expected 0", st_mis_miss); end
  endtask

  task automatic test_cache_replay;
    stream(8'd2, 8'd0, -1, 1'b0, 1'b0, 1090);
    checks++; if (st_src !== 1'b0) begin errors++; $display("[TB] FAIL replay_src: got %b expected 0", st_src); end
    checks++; if (st_mis_addr !== 0) begin errors++; $display("[TB] FAIL replay_rd_addr: got %0d bad expected 0", st_mis_addr); end
    checks++; if (st_wr_cnt !== 0 || st_mis_wr !== 0) begin errors++; $display("[TB] FAIL replay_no_write: got %0d writes expected 0", st_wr_cnt); end
    checks++; if (st_valid_cnt !== BYTES || st_mis_valid !== 0) begin errors++; $display("[TB] FAIL replay_valid: got %0d/%0d bad expected %0d/0", st_valid_cnt, st_mis_valid, BYTES); end
    checks++; if (st_done_cyc !== DONE_CYC) begin errors++; $display("[TB] FAIL replay_done: got %0d expected %0d", st_done_cyc, DONE_CYC); end
    checks++; if (st_cv_end !== 1'b1 || st_mis_miss !== 0) begin errors++; $display("[TB] FAIL replay_cv_miss: got %b/%0d expected 1/0", st_cv_end, st_mis_miss); end
  endtask

  task automatic test_cache_miss;
    rst = 1'b1;
    @(negedge clk125MHz);
    rst = 1'b0;
    stream(8'd3, 8'd4, -1, 1'b0, 1'b1, 1090);
    checks++; if (st_mis_miss !== 0) begin errors++; $display("[TB] FAIL miss_pulse: got %0d bad expected 0", st_mis_miss); end
    checks++; if (st_src !== 1'b1) begin errors++; $display("[TB] FAIL miss_src: got %b expected 1", st_src); end
    checks++; if (st_first_addr !== 24'd1440 || st_mis_addr !== 0) begin errors++; $display("[TB] FAIL miss_addr: got %0d/%0d bad expected 1440/0", st_first_addr, st_mis_addr); end
    checks++; if (st_wr_cnt !== 0) begin errors++; $display("[TB] FAIL miss_no_write: got %0d expected 0", st_wr_cnt); end
    checks++; if (st_cv_end !== 1'b0) begin errors++; $display("[TB] FAIL miss_cache_valid: got %b expected 0", st_cv_end); end
    checks++; if (st_valid_cnt !== BYTES || st_mis_valid !== 0) begin errors++; $display("[TB] FAIL miss_valid: got %0d/%0d bad expected %0d/0", st_valid_cnt, st_mis_valid, BYTES); end
  endtask

  task automatic test_max_segment;
    stream(8'd1, 8'd255, -1, 1'b0, 1'b0, 1090);
    checks++; if (st_first_addr !== 24'd91800) begin errors++; $display("[TB] FAIL max_first_addr: got %0d expected 91800", st_first_addr); end
    checks++; if (st_last_addr !== 24'd92159) begin errors++; $display("[TB] FAIL max_last_addr: got %0d expected 92159", st_last_addr); end
    checks++; if (st_mis_addr !== 0) begin errors++; $display("[TB] FAIL max_addr_seq: got %0d bad expected 0", st_mis_addr); end
    checks++; if (st_wr_cnt !== BYTES || st_cv_end !== 1'b1) begin errors++; $display("[TB] FAIL max_fill: got %0d/%b expected %0d/1", st_wr_cnt, st_cv_end, BYTES); end
  endtask

  task automatic test_abort;
    stream(8'd1, 8'd2, 500, 1'b0, 1'b0, 1090);
    checks++; if (st_valid_cnt !== 499 || st_mis_valid !== 0) begin errors++; $display("[TB] FAIL abort_valid: got %0d/%0d bad expected 499/0", st_valid_cnt, st_mis_valid); end
    checks++; if (st_mis_wr !== 0) begin errors++; $display("[TB] FAIL abort_wr: got %0d bad expected 0", st_mis_wr); end
    checks++; if (st_done_cnt !== 0) begin errors++; $display("[TB] FAIL abort_no_done: got %0d expected 0", st_done_cnt); end
    checks++; if (st_mis_busy !== 0) begin errors++; $display("[TB] FAIL abort_busy: got %0d bad expected 0", st_mis_busy); end
    checks++; if (st_cv_end !== 1'b0) begin errors++; $display("[TB] FAIL abort_cache_valid: got %b expected 0", st_cv_end); end
    stream(8'd1, 8'd1, -1, 1'b0, 1'b0, 1090);
    checks++; if (st_valid_cnt !== BYTES || st_done_cyc !== DONE_CYC || st_cv_end !== 1'b1) begin errors++; $display("[TB] FAIL abort_recover: got %0d/%0d/%b expected %0d/%0d/1", st_valid_cnt, st_done_cyc, st_cv_end, BYTES, DONE_CYC); end
    txid = 8'd1; segment_num = 8'd0; start = 1'b1; abort = 1'b1;
    @(negedge clk125MHz);
    start = 1'b0; abort = 1'b0;
    checks++; if (busy !== 1'b0 || cache_valid !== 1'b1) begin errors++; $display("[TB] FAIL abort_wins_start: got %b/%b expected 0/1", busy, cache_valid); end
    start = 1'b1;
    @(negedge clk125MHz);
    start = 1'b0;
    repeat (50) @(negedge clk125MHz);
    rst = 1'b1;
    @(negedge clk125MHz);
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || byte_valid !== 1'b0 || cache_wr_en !== 1'b0 || cache_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_mid_segment: got %b%b%b%b expected 0000", busy, byte_valid, cache_wr_en, cache_valid); end
  endtask

  task automatic test_back_to_back;
    stream(8'd1, 8'd5, -1, 1'b1, 1'b0, DONE_CYC + 1);
    checks++; if (st_valid_cnt !== BYTES || st_mis_valid !== 0 || st_mis_busy !== 0) begin errors++; $display("[TB] FAIL b2b_first: got %0d/%0d/%0d expected %0d/0/0", st_valid_cnt, st_mis_valid, st_mis_busy, BYTES); end
    checks++; if (st_mis_addr !== 0 || st_wr_cnt !== BYTES) begin errors++; $display("[TB] FAIL b2b_first_addr: got %0d/%0d expected 0/%0d", st_mis_addr, st_wr_cnt, BYTES); end
    stream(8'd2, 8'd5, -1, 1'b1, 1'b0, 1090);
    checks++; if (st_src !== 1'b0 || st_mis_miss !== 0) begin errors++; $display("[TB] FAIL b2b_second_src: got %b/%0d expected 0/0", st_src, st_mis_miss); end
    checks++; if (st_valid_cnt !== BYTES || st_mis_valid !== 0 || st_mis_busy !== 0) begin errors++; $display("[TB] FAIL b2b_second: got %0d/%0d/%0d expected %0d/0/0", st_valid_cnt, st_mis_valid, st_mis_busy, BYTES); end
    checks++; if (st_done_cnt !== 1 || st_done_cyc !== DONE_CYC || st_wr_cnt !== 0) begin errors++; $display("[TB] FAIL b2b_second_done: got %0d at %0d wr %0d expected 1 at %0d wr 0", st_done_cnt, st_done_cyc, st_wr_cnt, DONE_CYC); end
  endtask

  initial begin
    $display("[TB] tx_segment_reader bench starting");
    test_reset;
    test_fill;
    test_cache_replay;
    test_cache_miss;
    test_max_segment;
    test_abort;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
